// File: rtl/adder_slice_sequencer.sv
// Multi-cycle WIDTH-bit adder that time-shares one external SLICE_W-bit ripple adder,
// least-significant slice first, with the inter-slice carry held in a register.
module adder_slice_sequencer #(
  parameter  int SLICE_W    = 8,
  parameter  int NUM_SLICES = 4,
  localparam int WIDTH      = SLICE_W * NUM_SLICES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   sum,
  output logic               carry,
  output logic               overflow,
  output logic [SLICE_W-1:0] slice_a,
  output logic [SLICE_W-1:0] slice_b,
  output logic               slice_cin,
  input  logic [SLICE_W-1:0] slice_sum,
  input  logic               slice_cout
);

  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] part_reg;
  logic             c_reg;
  logic             accept;
  logic             last_slice;
  logic [WIDTH-1:0] sum_next;
  logic             overflow_next;

  assign last_slice = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The closing edge of DONE may accept a new request, so back-to-back
  // operations complete every NUM_SLICES+1 cycles.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_slice) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Slice operands reach the shared adder only while running.
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    if (state == RUN) begin
      slice_cin = c_reg;
      for (int i = 0; i < NUM_SLICES; i++) begin
        if (idx == IDX_W'(i)) begin
          slice_a = a_reg[i*SLICE_W +: SLICE_W];
          slice_b = b_reg[i*SLICE_W +: SLICE_W];
        end
      end
    end
  end

  always_comb begin
    sum_next                     = part_reg;
    sum_next[WIDTH-1 -: SLICE_W] = slice_sum;
    overflow_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                    (slice_sum[SLICE_W-1] != a_reg[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      c_reg    <= 1'b0;
      part_reg <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_reg <= in1;
      b_reg <= in2;
      c_reg <= cin;
      idx   <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NUM_SLICES; i++) begin
        if (idx == IDX_W'(i)) begin
          part_reg[i*SLICE_W +: SLICE_W] <= slice_sum;
        end
      end
      c_reg <= slice_cout;
      if (last_slice) begin
        sum      <= sum_next;
        carry    <= slice_cout;
        overflow <= overflow_next;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_slice_sequencer.sv
// Randomised self-checking bench for adder_slice_sequencer; the bench also plays the
// external 8-bit ripple adder and predicts results with plain wide arithmetic.
module tb_adder_slice_sequencer;

  localparam int SLICE_W    = 8;
  localparam int NUM_SLICES = 4;
  localparam int WIDTH      = SLICE_W * NUM_SLICES;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic               cin;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic               overflow;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic               slice_cin;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  int n_checks = 0;
  int n_fail   = 0;

  // Cycles left in the current operation: 0 idle, NUM_SLICES+1 first slice, 1 done.
  int               rem = 0;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_c;
  logic [WIDTH-1:0] exp_sum, held_sum;
  logic             exp_carry, exp_ovf, held_carry, held_ovf;

  adder_slice_sequencer #(.SLICE_W(SLICE_W), .NUM_SLICES(NUM_SLICES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in1        (in1),
    .in2        (in2),
    .cin        (cin),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .carry      (carry),
    .overflow   (overflow),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_sum  (slice_sum),
    .slice_cout (slice_cout)
  );

  always #5 clk = ~clk;

  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {8'b0, slice_cin};

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic model_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic c);
    longint unsigned u;
    longint          s;
    longint          lo;
    longint          hi;
    u  = 64'(a) + 64'(b) + 64'(c);
    s  = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    lo = -(longint'(1) <<< 31);
    hi = (longint'(1) <<< 31) - 1;
    exp_sum   = u[31:0];
    exp_carry = u[32];
    exp_ovf   = (s > hi) || (s < lo);
  endtask

  function automatic logic carry_into(input int k);
    longint unsigned mask;
    longint unsigned t;
    if (k == 0) return op_c;
    mask = (64'd1 << (SLICE_W * k)) - 64'd1;
    t    = (64'(op_a) & mask) + (64'(op_b) & mask) + 64'(op_c);
    return t[SLICE_W * k];
  endfunction

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom % 5)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: check the cycle at the falling edge, then drive the next edge.
  task automatic apply_stimulus(input logic s, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic c, input logic r);
    int k;
    @(negedge clk);
    if (rem == 1) begin
      held_sum   = exp_sum;
      held_carry = exp_carry;
      held_ovf   = exp_ovf;
    end
    check_output("busy", busy, rem > 0);
    check_output("done", done, rem == 1);
    check_output("sum", sum, held_sum);
    check_output("carry", carry, held_carry);
    check_output("overflow", overflow, held_ovf);
    if (rem >= 2) begin
      k = NUM_SLICES + 1 - rem;
      check_output("slice_a", slice_a, 8'(op_a >> (SLICE_W * k)));
      check_output("slice_b", slice_b, 8'(op_b >> (SLICE_W * k)));
      check_output("slice_cin", slice_cin, carry_into(k));
    end else begin
      check_output("slice_a_idle", slice_a, 8'h00);
      check_output("slice_b_idle", slice_b, 8'h00);
      check_output("slice_cin_idle", slice_cin, 1'b0);
    end
    start = s;
    in1   = a;
    in2   = b;
    cin   = c;
    rst_n = r;
    if (!r) begin
      rem        = 0;
      held_sum   = '0;
      held_carry = 1'b0;
      held_ovf   = 1'b0;
    end else if (s && rem <= 1) begin
      op_a = a;
      op_b = b;
      op_c = c;
      model_add(a, b, c);
      rem = NUM_SLICES + 1;
    end else if (rem > 0) begin
      rem--;
    end
  endtask

  // Single request pulse, with operand inputs scrambled while it runs.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    apply_stimulus(1'b1, a, b, c, 1'b1);
    repeat (NUM_SLICES + 1) apply_stimulus(1'b0, $urandom, $urandom, 1'($urandom), 1'b1);
  endtask

  initial begin
    held_sum   = '0;
    held_carry = 1'b0;
    held_ovf   = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    cin   = 1'b0;
    repeat (3) @(posedge clk);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1);

    $display("[TB] directed operations");
    run_op(32'h0000_0000, 32'h0000_0000, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    $display("[TB] start held every cycle");
    repeat (27) apply_stimulus(1'b1, $urandom, $urandom, 1'($urandom), 1'b1);
    repeat (3) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1);

    $display("[TB] reset during slice 2");
    apply_stimulus(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1);
    apply_stimulus(1'b0, $urandom, $urandom, 1'b0, 1'b1);
    apply_stimulus(1'b0, $urandom, $urandom, 1'b0, 1'b1);
    apply_stimulus(1'b0, $urandom, $urandom, 1'b0, 1'b0);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

    $display("[TB] random traffic");
    repeat (120) apply_stimulus(($urandom % 3) == 0, rand_operand(), rand_operand(),
                                1'($urandom), 1'b1);
    repeat (NUM_SLICES + 2) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
